// File: rtl/p2sc_tx.sv
// p2sc_tx: parallel-to-serial transmitter with optional parity.
// Accepts a DATA_W-bit word over load/ready and shifts it out LSB first,
// one bit per clk, followed by a parity bit and a one-cycle done pulse.
// Side-band strobes mark data and parity cycles for a loopback receiver.
module p2sc_tx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] p_in,
  input  logic              load,
  output logic              ready,
  output logic              s_out,
  output logic              shift_en,
  output logic              par_en,
  output logic              done,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              ready_q, ready_d;
  logic              s_out_q, s_out_d;
  logic              shift_en_q, shift_en_d;
  logic              par_en_q, par_en_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Next-state logic; outputs are decoded from the next state so that every
  // output comes straight from a flop while still appearing in the cycle
  // right after the transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          shift_d = p_in;
          par_d   = (^p_in) ^ (ODD_PARITY != 0);
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        shift_d = shift_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // hold the counter on the last bit so it never wraps in a frame
          state_d = (PARITY_EN != 0) ? ST_PARITY : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    s_out_d = 1'b0;
    if (state_d == ST_SHIFT) begin
      s_out_d = shift_d[0];
    end else if (state_d == ST_PARITY) begin
      s_out_d = par_d;
    end
    shift_en_d = (state_d == ST_SHIFT);
    par_en_d   = (state_d == ST_PARITY);
    done_d     = (state_d == ST_DONE);
    ready_d    = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      ready_q    <= 1'b1;
      s_out_q    <= 1'b0;
      shift_en_q <= 1'b0;
      par_en_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      ready_q    <= ready_d;
      s_out_q    <= s_out_d;
      shift_en_q <= shift_en_d;
      par_en_q   <= par_en_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign ready    = ready_q;
  assign s_out    = s_out_q;
  assign shift_en = shift_en_q;
  assign par_en   = par_en_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_p2sc_tx.sv
// Scoreboard bench for p2sc_tx: three builds (even parity, odd parity,
// no parity) share one stimulus stream. Each build has a predictor that
// queues the expected frame on accept and a monitor that rebuilds the frame
// from s_out/shift_en/par_en and checks it when done pulses.
module tb_p2sc_tx;

  localparam int DW  = 8;
  localparam int PER = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [DW-1:0] p_in;
  logic          mon_en = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  always #(PER/2) clk = ~clk;

  task automatic chk(input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cfg%0d: got %0h expected %0h", name, g, act, exp);
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int PEN   = (g == 2) ? 0 : 1;
    localparam int ODD   = (g == 1) ? 1 : 0;
    localparam int FRAME = DW + PEN + 1;

    logic ready, s_out, shift_en, par_en, done, busy;

    p2sc_tx #(.DATA_W(DW), .PARITY_EN(PEN), .ODD_PARITY(ODD)) dut (
      .clk      (clk),
      .rst      (rst),
      .p_in     (p_in),
      .load     (load),
      .ready    (ready),
      .s_out    (s_out),
      .shift_en (shift_en),
      .par_en   (par_en),
      .done     (done),
      .busy     (busy)
    );

    int            m_cnt = 0;
    logic [DW-1:0] word_q[$];
    logic          par_q[$];
    time           tacc_q[$];

    logic [DW-1:0] bits = '0;
    int            nbits = 0;
    int            pseen = 0;
    logic          pbit = 1'b0;

    // Predictor: busy countdown; an accept queues word, parity and time.
    always @(posedge clk) begin
      if (rst) begin
        m_cnt = 0;
        word_q.delete();
        par_q.delete();
        tacc_q.delete();
      end else if (m_cnt == 0) begin
        if (load) begin
          word_q.push_back(p_in);
          par_q.push_back((^p_in) ^ (ODD != 0));
          tacc_q.push_back($time);
          m_cnt = FRAME;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end

    // Monitor: per-cycle handshake/strobe checks and frame reassembly.
    always @(negedge clk) begin
      logic [DW-1:0] w;
      logic          p;
      time           t;
      if (mon_en) begin
        chk("ready", g, ready, m_cnt == 0);
        chk("busy",  g, busy,  m_cnt != 0);
        chk("strobe_excl", g, (shift_en & par_en) | (done & (shift_en | par_en)), 0);
        chk("sout_idle", g, (!shift_en && !par_en) ? s_out : 1'b0, 0);
        if (m_cnt == 0) begin
          bits  = '0;
          nbits = 0;
          pseen = 0;
        end
        if (shift_en) begin
          if (nbits < DW) bits[nbits] = s_out;
          nbits++;
        end
        if (par_en) begin
          pbit = s_out;
          pseen++;
        end
        if (done) begin
          if (word_q.size() == 0) begin
            chk("spurious_done", g, 1, 0);
          end else begin
            w = word_q.pop_front();
            p = par_q.pop_front();
            t = tacc_q.pop_front();
            chk("data",      g, bits,  w);
            chk("nbits",     g, nbits, DW);
            chk("par_slots", g, pseen, PEN);
            if (pseen != 0) chk("parity", g, pbit, p);
            chk("done_lat",  g, int'($time - t), (FRAME - 1) * PER + PER / 2);
          end
          bits  = '0;
          nbits = 0;
          pseen = 0;
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] w);
    @(negedge clk);
    load = 1'b1;
    p_in = w;
    @(negedge clk);
    load = 1'b0;
    p_in = DW'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 0, {cfg[0].ready, cfg[0].busy, cfg[0].s_out, cfg[0].shift_en, cfg[0].par_en, cfg[0].done}, 6'b100000);
    chk(name, 1, {cfg[1].ready, cfg[1].busy, cfg[1].s_out, cfg[1].shift_en, cfg[1].par_en, cfg[1].done}, 6'b100000);
    chk(name, 2, {cfg[2].ready, cfg[2].busy, cfg[2].s_out, cfg[2].shift_en, cfg[2].par_en, cfg[2].done}, 6'b100000);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    p_in = '0;
    idle(3);
    rst = 1'b0;
    chk_reset_outputs("reset_vals");
    mon_en = 1'b1;

    // directed words: A5 (even parity 0), 01 (even 1 / odd 0), FF (even 0)
    send(8'hA5); idle(12);
    send(8'h01); idle(12);
    send(8'hFF); idle(12);

    // load held high: two back-to-back frames, p_in swapped after first accept
    @(negedge clk);
    load = 1'b1;
    p_in = 8'h3C;
    idle(3);
    p_in = 8'hC3;
    idle(12);
    load = 1'b0;
    p_in = 8'h00;
    idle(14);

    // load pulse with a new word mid-frame must be ignored
    send(8'h96);
    idle(2);
    load = 1'b1;
    p_in = 8'h00;
    @(negedge clk);
    load = 1'b0;
    idle(12);

    // reset in the middle of a frame, coincident with load
    send(8'hE7);
    idle(4);
    rst  = 1'b1;
    load = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    chk_reset_outputs("abort_vals");
    send(8'h5A); idle(12);

    // random words with gaps that sometimes land a load while busy
    for (int i = 0; i < 40; i++) begin
      send(DW'($urandom));
      idle($urandom_range(8, 13));
    end
    idle(14);

    chk("drain", 0, cfg[0].word_q.size(), 0);
    chk("drain", 1, cfg[1].word_q.size(), 0);
    chk("drain", 2, cfg[2].word_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
